// File: rtl/intalu_issue_queue.sv
// ---------------------------------------------------------------------------
// intalu_issue_queue
//
// Integer-ALU issue queue sitting behind the dispatcher. Holds up to DEPTH
// dispatched packets in a compacting, age-ordered array (slot 0 = oldest,
// occupied slots are always 0..count-1). Source readiness is tracked per
// entry and woken by writeback broadcasts. Each cycle the oldest entry whose
// two sources are ready is offered to the ALU on a valid/ready handshake.
//
// Packet layout:
//   [54] rs1_rdy  [53] rs2_rdy  [52:48] rs1  [47:43] rs2  [42:0] payload
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   resetn       synchronous active-low reset
//   flush        synchronous clear of all entries
//   enq_valid    dispatcher presents enq_data this cycle
//   enq_data     dispatch packet
//   full         count == DEPTH (registered-state derived)
//   empty        count == 0 (registered-state derived)
//   count        number of occupied entries
//   wb_valid     writeback broadcast valid
//   wb_rd        destination register being written back
//   issue_valid  an occupied entry has both sources ready
//   issue_data   selected packet, zero when issue_valid is low
//   issue_ready  ALU accepts the issued packet
// ---------------------------------------------------------------------------
module intalu_issue_queue #(
  parameter int FIELD_WIDTH = 55,
  parameter int DEPTH       = 4,
  parameter int CW          = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   enq_valid,
  input  logic [FIELD_WIDTH-1:0] enq_data,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  output logic                   issue_valid,
  output logic [FIELD_WIDTH-1:0] issue_data,
  input  logic                   issue_ready
);

  localparam int RS1_RDY = 54;
  localparam int RS2_RDY = 53;
  localparam int RS1_HI  = 52;
  localparam int RS1_LO  = 48;
  localparam int RS2_HI  = 47;
  localparam int RS2_LO  = 43;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  // Set the ready bit of each source whose register matches a live writeback.
  function automatic logic [FIELD_WIDTH-1:0] wake_entry(
    input logic [FIELD_WIDTH-1:0] e,
    input logic                   hit,
    input logic [4:0]             rd
  );
    logic [FIELD_WIDTH-1:0] r;
    r          = e;
    r[RS1_RDY] = e[RS1_RDY] | (hit && (e[RS1_HI:RS1_LO] == rd));
    r[RS2_RDY] = e[RS2_RDY] | (hit && (e[RS2_HI:RS2_LO] == rd));
    return r;
  endfunction

  logic [FIELD_WIDTH-1:0] ent_q     [DEPTH];
  logic [FIELD_WIDTH-1:0] ent_d     [DEPTH];
  logic [FIELD_WIDTH-1:0] woken_s   [DEPTH];
  logic [FIELD_WIDTH-1:0] shifted_s [DEPTH];
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;

  logic [DEPTH-1:0]       rdy_s;
  logic [CW-1:0]          sel_s;
  logic                   issue_valid_s;
  logic [FIELD_WIDTH-1:0] issue_data_s;
  logic                   full_s;
  logic                   fire_s;
  logic                   enq_acc_s;
  logic                   wb_hit_s;
  logic [CW-1:0]          ins_pos_s;
  logic [FIELD_WIDTH-1:0] new_entry_s;

  assign full_s    = (count_q == COUNT_FULL);
  assign full      = full_s;
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign wb_hit_s  = wb_valid && (wb_rd != 5'd0);
  assign enq_acc_s = enq_valid && !full_s;
  assign fire_s    = issue_valid_s && issue_ready;

  // Oldest-ready select; looks only at registered entries so the issue side
  // never sees same-cycle enqueue or wakeup.
  always_comb begin
    issue_valid_s = 1'b0;
    sel_s         = {CW{1'b0}};
    issue_data_s  = {FIELD_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rdy_s[i] = (CW'(i) < count_q) && ent_q[i][RS1_RDY] && ent_q[i][RS2_RDY];
    end
    // Walk from youngest to oldest so the last hit left standing is the oldest.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      issue_valid_s = issue_valid_s | rdy_s[i];
      sel_s         = rdy_s[i] ? CW'(i) : sel_s;
    end
    for (int i = 0; i < DEPTH; i++) begin
      issue_data_s = issue_data_s |
                     ((issue_valid_s && (sel_s == CW'(i))) ? ent_q[i] : {FIELD_WIDTH{1'b0}});
    end
  end

  assign issue_valid = issue_valid_s;
  assign issue_data  = issue_data_s;

  // Next-state entries: wakeup, compaction on issue, then insertion.
  always_comb begin
    // Ready at insertion also covers a same-cycle writeback and register x0.
    new_entry_s          = wake_entry(enq_data, wb_hit_s, wb_rd);
    new_entry_s[RS1_RDY] = new_entry_s[RS1_RDY] | (enq_data[RS1_HI:RS1_LO] == 5'd0);
    new_entry_s[RS2_RDY] = new_entry_s[RS2_RDY] | (enq_data[RS2_HI:RS2_LO] == 5'd0);

    // When an issue fires the freed slot is filled by shifting, so the
    // incoming packet lands one slot lower than the current count.
    ins_pos_s = fire_s ? (count_q - {{(CW-1){1'b0}}, 1'b1}) : count_q;

    for (int i = 0; i < DEPTH; i++) begin
      woken_s[i] = (CW'(i) < count_q) ? wake_entry(ent_q[i], wb_hit_s, wb_rd) : ent_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted_s[i] = woken_s[i + 1];
    end
    shifted_s[DEPTH-1] = {FIELD_WIDTH{1'b0}};

    for (int i = 0; i < DEPTH; i++) begin
      if (enq_acc_s && (ins_pos_s == CW'(i))) begin
        ent_d[i] = new_entry_s;
      end else if (fire_s && (CW'(i) >= sel_s)) begin
        ent_d[i] = shifted_s[i];
      end else begin
        ent_d[i] = woken_s[i];
      end
    end

    case ({enq_acc_s, fire_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset and flush.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= {FIELD_WIDTH{1'b0}};
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_intalu_issue_queue.sv
module tb_intalu_issue_queue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic [54:0] enq_data = 55'd0;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic        issue_valid;
  logic [54:0] issue_data;
  logic        issue_ready = 1'b0;

  int total = 0;
  int bad = 0;

  intalu_issue_queue #(.FIELD_WIDTH(55), .DEPTH(4), .CW(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data),
    .full(full), .empty(empty), .count(count),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_valid(issue_valid), .issue_data(issue_data),
    .issue_ready(issue_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [54:0] pkt(input logic r1, input logic r2,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [42:0] pl);
    return {r1, r2, rs1, rs2, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [54:0] a, x, y, z, r1;
  logic [54:0] p [5];
  logic [54:0] q [4];

  initial begin
    // Reset
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_iv", 64'(issue_valid), 64'd0);
    chk("rst_idata", 64'(issue_data), 64'd0);

    // A waits on rs1=3, woken by writeback
    a = pkt(1'b0, 1'b0, 5'd3, 5'd0, 43'h123);
    enq_valid = 1'b1; enq_data = a;
    tick();
    enq_valid = 1'b0;
    chk("a_count", 64'(count), 64'd1);
    chk("a_iv0", 64'(issue_valid), 64'd0);
    tick();
    chk("a_iv1", 64'(issue_valid), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    wb_valid = 1'b0; wb_rd = 5'd0;
    chk("a_iv_woken", 64'(issue_valid), 64'd1);
    chk("a_idata", 64'(issue_data), 64'(pkt(1'b1, 1'b1, 5'd3, 5'd0, 43'h123)));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("a_count_after", 64'(count), 64'd0);
    chk("a_empty_after", 64'(empty), 64'd1);

    // Fill with four ready packets, drop a fifth, drain in order
    for (int k = 0; k < 5; k++) begin
      p[k] = pkt(1'b1, 1'b1, 5'(k + 1), 5'(k + 2), 43'(16'hA000 + k));
    end
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1; enq_data = p[k];
      tick();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    enq_data = p[4];
    tick();
    enq_valid = 1'b0;
    chk("drop_count", 64'(count), 64'd4);
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_iv%0d", k), 64'(issue_valid), 64'd1);
      chk($sformatf("drain_p%0d", k), 64'(issue_data), 64'(p[k]));
      tick();
    end
    issue_ready = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);

    // Younger ready Y overtakes older unready X
    x = pkt(1'b0, 1'b1, 5'd5, 5'd9, 43'h0BEEF);
    y = pkt(1'b1, 1'b1, 5'd6, 5'd7, 43'h0CAFE);
    enq_valid = 1'b1; enq_data = x;
    tick();
    enq_data = y;
    tick();
    enq_valid = 1'b0;
    chk("xy_iv", 64'(issue_valid), 64'd1);
    chk("xy_first_y", 64'(issue_data), 64'(y));
    issue_ready = 1'b1;
    tick();
    chk("xy_count", 64'(count), 64'd1);
    chk("xy_x_waits", 64'(issue_valid), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    tick();
    wb_valid = 1'b0; wb_rd = 5'd0;
    chk("x_iv", 64'(issue_valid), 64'd1);
    chk("x_idata", 64'(issue_data), 64'(pkt(1'b1, 1'b1, 5'd5, 5'd9, 43'h0BEEF)));
    tick();
    issue_ready = 1'b0;
    chk("x_count", 64'(count), 64'd0);

    // Enqueue while full and issuing: dropped; next cycle stored at slot 2
    for (int k = 0; k < 4; k++) begin
      q[k] = pkt(1'b1, 1'b1, 5'(k + 10), 5'(k + 20), 43'(16'hB000 + k));
      enq_valid = 1'b1; enq_data = q[k];
      tick();
    end
    r1 = pkt(1'b1, 1'b1, 5'd30, 5'd31, 43'h0D00D);
    enq_data = r1; issue_ready = 1'b1;
    tick();
    chk("fullissue_count", 64'(count), 64'd3);
    chk("fullissue_head", 64'(issue_data), 64'(q[1]));
    tick();
    enq_valid = 1'b0; issue_ready = 1'b0;
    chk("both_count", 64'(count), 64'd3);
    chk("both_head", 64'(issue_data), 64'(q[2]));
    issue_ready = 1'b1;
    tick();
    chk("both_s1", 64'(issue_data), 64'(q[3]));
    tick();
    chk("both_s2_r", 64'(issue_data), 64'(r1));
    tick();
    issue_ready = 1'b0;
    chk("both_empty", 64'(empty), 64'd1);

    // Same-cycle bypass at insertion
    z = pkt(1'b1, 1'b0, 5'd9, 5'd7, 43'h0F00D);
    enq_valid = 1'b1; enq_data = z; wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    enq_valid = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
    chk("z_iv", 64'(issue_valid), 64'd1);
    chk("z_idata", 64'(issue_data), 64'(pkt(1'b1, 1'b1, 5'd9, 5'd7, 43'h0F00D)));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("z_count", 64'(count), 64'd0);

    // Flush with three entries
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1; enq_data = p[k];
      tick();
    end
    enq_valid = 1'b0;
    chk("preflush_count", 64'(count), 64'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_iv", 64'(issue_valid), 64'd0);
    chk("flush_idata", 64'(issue_data), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
